// File: rtl/rle_tx_scheduler.sv
// rle_tx_scheduler
// Shares one uart_tx serializer between the R, G and B RLE code streams.
// Each stream owns a one-entry holding buffer. A round-robin FSM hands the
// buffered codes to the uart_tx one at a time. tx_ch tags the code in flight
// so the receive side can demultiplex it.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   r_code    in   R code word        r_load  in  1-cycle capture strobe for R
//   g_code    in   G code word        g_load  in  1-cycle capture strobe for G
//   b_code    in   B code word        b_load  in  1-cycle capture strobe for B
//   full      out  {B,G,R} holding buffer occupied
//   ovf       out  {B,G,R} sticky: a load hit an occupied buffer
//   tx_din    out  code presented to uart_tx, stable from ISSUE through WAIT
//   tx_start  out  1-cycle start pulse to uart_tx
//   tx_ch     out  channel of the code in flight (0=R 1=G 2=B)
//   tx_done   in   uart_tx completion pulse
//   timeout   out  sticky: a WAIT ran out before tx_done arrived
module rle_tx_scheduler #(
    parameter int CW       = 16,
    parameter int GAP_CLKS = 435,
    parameter int TIMEOUT  = 8192
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] r_code,
    input  logic          r_load,
    input  logic [CW-1:0] g_code,
    input  logic          g_load,
    input  logic [CW-1:0] b_code,
    input  logic          b_load,
    output logic [2:0]    full,
    output logic [2:0]    ovf,
    output logic [CW-1:0] tx_din,
    output logic          tx_start,
    output logic [1:0]    tx_ch,
    input  logic          tx_done,
    output logic          timeout
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CLKS) ? TIMEOUT : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      last_q;
    logic [1:0]      txCh_q;
    logic [CW-1:0]   txDin_q;
    logic            txStart_q;
    logic            timeout_q;
    logic [2:0]      full_q;
    logic [2:0]      ovf_q;
    logic [CW-1:0]   code_q [3];

    logic [CW-1:0]   inCode [3];
    logic [2:0]      inLoad;
    logic            waitEnd;
    logic            waitExpired;
    logic [2:0]      release_d;
    logic            grantValid_d;
    logic [1:0]      grantCh_d;
    logic [1:0]      cand;

    // A zero code is the idle code, so a strobe carrying zero is not a load.
    assign inCode[0] = r_code;
    assign inCode[1] = g_code;
    assign inCode[2] = b_code;
    assign inLoad    = {b_load && (b_code != '0),
                        g_load && (g_code != '0),
                        r_load && (r_code != '0)};

    // WAIT ends on tx_done or when the cycle budget is used up; tx_done wins a tie.
    assign waitEnd     = (state_q == ST_WAIT) &&
                         (tx_done || (cnt_q == CNT_W'(TIMEOUT - 1)));
    assign waitExpired = (state_q == ST_WAIT) && !tx_done &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
    assign release_d   = waitEnd ? (3'b001 << txCh_q) : 3'b000;

    // Round-robin pick: first occupied buffer after the last one served.
    always_comb begin
        grantValid_d = 1'b0;
        grantCh_d    = last_q;
        cand         = last_q;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!grantValid_d && full_q[cand]) begin
                grantValid_d = 1'b1;
                grantCh_d    = cand;
            end
        end
    end

    // A buffer released this cycle can take a new code in the same cycle;
    // otherwise a load into an occupied buffer is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inLoad[i]) begin
                    if (!full_q[i] || release_d[i]) begin
                        code_q[i] <= inCode[i];
                        full_q[i] <= 1'b1;
                    end else begin
                        ovf_q[i] <= 1'b1;
                    end
                end else if (release_d[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    // Scheduler FSM. The granted buffer stays marked full until WAIT ends, so
    // the word being transmitted cannot be overwritten underneath uart_tx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 2'd2;
            txCh_q    <= 2'd0;
            txDin_q   <= '0;
            txStart_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            txStart_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grantValid_d) begin
                        txDin_q   <= code_q[grantCh_d];
                        txCh_q    <= grantCh_d;
                        txStart_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (waitEnd) begin
                        if (waitExpired) begin
                            timeout_q <= 1'b1;
                        end
                        last_q  <= txCh_q;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign ovf      = ovf_q;
    assign tx_din   = txDin_q;
    assign tx_start = txStart_q;
    assign tx_ch    = txCh_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_rle_tx_scheduler.sv
// Testbench for rle_tx_scheduler. A transaction-level reference model tracks
// buffer contents, the round-robin pointer and the times at which the shared
// transmitter becomes free, and every cycle is compared against it.
module tb_rle_tx_scheduler;

    localparam int CW  = 16;
    localparam int GAP = 12;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] r_code, g_code, b_code;
    logic          r_load, g_load, b_load;
    logic [2:0]    full, ovf;
    logic [CW-1:0] tx_din;
    logic          tx_start;
    logic [1:0]    tx_ch;
    logic          tx_done;
    logic          timeout;

    rle_tx_scheduler #(.CW(CW), .GAP_CLKS(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .r_code(r_code), .r_load(r_load),
        .g_code(g_code), .g_load(g_load),
        .b_code(b_code), .b_load(b_load),
        .full(full), .ovf(ovf),
        .tx_din(tx_din), .tx_start(tx_start), .tx_ch(tx_ch),
        .tx_done(tx_done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            edgeNum;
    bit            mFull [3];
    logic [CW-1:0] mCode [3];
    logic [2:0]    mOvf;
    bit            mTimeout;
    int            mLast;
    bit            mBusy;
    int            mCh;
    int            issueEdge;
    int            freeEdge;
    int            doneEdge;
    int            lastRelEdge;
    logic [CW-1:0] mDin;
    int            mTxCh;
    bit            mStart;

    // uart_tx model controls
    bit noDone;
    bit spurious;
    int maxDelay;

    logic [1:0]    obsCh [$];
    logic [CW-1:0] obsDin [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d",
                     tag, actual, expected, edgeNum);
        end
    endtask

    function automatic logic [2:0] packFull();
        return {mFull[2], mFull[1], mFull[0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mFull[i] = 1'b0;
            mCode[i] = '0;
        end
        mOvf        = '0;
        mTimeout    = 1'b0;
        mLast       = 2;
        mBusy       = 1'b0;
        mCh         = 0;
        issueEdge   = 0;
        freeEdge    = 0;
        doneEdge    = -1;
        lastRelEdge = -1;
        mDin        = '0;
        mTxCh       = 0;
        mStart      = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs that were driven.
    task automatic modelStep();
        bit            fb [3];
        bit            ld [3];
        logic [CW-1:0] cd [3];
        int            rel;
        int            c;
        fb  = mFull;
        ld  = '{r_load, g_load, b_load};
        cd  = '{r_code, g_code, b_code};
        rel = -1;
        mStart = 1'b0;
        if (mBusy && edgeNum >= issueEdge + 2 &&
            (tx_done || edgeNum == issueEdge + 1 + TMO)) begin
            if (!tx_done) mTimeout = 1'b1;
            rel         = mCh;
            mBusy       = 1'b0;
            mLast       = mCh;
            freeEdge    = edgeNum + GAP + 1;
            lastRelEdge = edgeNum;
            doneEdge    = -1;
        end else if (!mBusy && edgeNum >= freeEdge) begin
            for (int k = 1; k <= 3; k++) begin
                c = (mLast + k) % 3;
                if (!mBusy && fb[c]) begin
                    mBusy     = 1'b1;
                    mCh       = c;
                    issueEdge = edgeNum;
                    mStart    = 1'b1;
                    mDin      = mCode[c];
                    mTxCh     = c;
                    doneEdge  = noDone ? -1 : edgeNum + 1 + int'($urandom_range(1, maxDelay));
                end
            end
        end
        for (int x = 0; x < 3; x++) begin
            if (ld[x] && cd[x] != '0) begin
                if (!fb[x] || rel == x) begin
                    mCode[x] = cd[x];
                    mFull[x] = 1'b1;
                end else begin
                    mOvf[x] = 1'b1;
                end
            end else if (rel == x) begin
                mFull[x] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic applyStimulus(input logic [2:0] ld, input logic [CW-1:0] rc,
                                 input logic [CW-1:0] gc, input logic [CW-1:0] bc);
        r_load = ld[0]; r_code = rc;
        g_load = ld[1]; g_code = gc;
        b_load = ld[2]; b_code = bc;
        tx_done = (mBusy && doneEdge == edgeNum + 1) ||
                  (spurious && !mBusy && ($urandom_range(0, 15) == 0));
        @(posedge clk);
        edgeNum++;
        modelStep();
        #1;
        checkOutput("full", full, packFull());
        checkOutput("ovf", ovf, mOvf);
        checkOutput("timeout", timeout, mTimeout);
        checkOutput("tx_start", tx_start, mStart);
        checkOutput("tx_din", tx_din, mDin);
        checkOutput("tx_ch", tx_ch, mTxCh);
        if (tx_start === 1'b1) begin
            obsCh.push_back(tx_ch);
            obsDin.push_back(tx_din);
            if (lastRelEdge >= 0)
                checkOutput("gap_after_done", edgeNum - lastRelEdge > GAP, 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(3'b000, '0, '0, '0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mBusy || edgeNum < freeEdge || packFull() != 3'b000) && guard < 3000) begin
            applyStimulus(3'b000, '0, '0, '0);
            guard++;
        end
        checkOutput("drain_bound", guard >= 3000, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic applyReset();
        r_load = 1'b0; g_load = 1'b0; b_load = 1'b0;
        r_code = '0; g_code = '0; b_code = '0;
        tx_done = 1'b0;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_full", full, 3'b000);
        checkOutput("rst_ovf", ovf, 3'b000);
        checkOutput("rst_tx_start", tx_start, 1'b0);
        checkOutput("rst_tx_din", tx_din, 16'h0000);
        checkOutput("rst_tx_ch", tx_ch, 2'd0);
        checkOutput("rst_timeout", timeout, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        obsCh.delete();
        obsDin.delete();
    endtask

    initial begin
        int guard;
        int startEdge;
        int starts;
        edgeNum  = 0;
        noDone   = 1'b0;
        spurious = 1'b0;
        maxDelay = 30;
        modelReset();
        #3;
        applyReset();

        // Single R load: buffer fills, start pulse two cycles after the load.
        applyStimulus(3'b001, 16'h1203, '0, '0);
        checkOutput("t1_full", full, 3'b001);
        idle(1);
        checkOutput("t1_start", tx_start, 1'b1);
        checkOutput("t1_din", tx_din, 16'h1203);
        checkOutput("t1_ch", tx_ch, 2'd0);
        drain();

        // All three loaded together: served R, G, B.
        applyReset();
        applyStimulus(3'b111, 16'h0101, 16'h0202, 16'h0303);
        drain();
        checkOutput("t2_count", obsCh.size(), 3);
        if (obsCh.size() == 3) begin
            checkOutput("t2_ch0", obsCh[0], 0);
            checkOutput("t2_ch1", obsCh[1], 1);
            checkOutput("t2_ch2", obsCh[2], 2);
        end

        // Second G load while G is in flight is dropped and flagged.
        applyReset();
        applyStimulus(3'b010, '0, 16'h0A05, '0);
        idle(1);
        applyStimulus(3'b010, '0, 16'h0B07, '0);
        drain();
        idle(5);
        checkOutput("t3_ovf", ovf, 3'b010);
        checkOutput("t3_count", obsDin.size(), 1);
        if (obsDin.size() >= 1) checkOutput("t3_din", obsDin[0], 16'h0A05);

        // B load coinciding with the tx_done that releases B is accepted.
        applyReset();
        applyStimulus(3'b100, '0, '0, 16'hB004);
        idle(1);
        guard = 0;
        while (mBusy && doneEdge != edgeNum + 1 && guard < 200) begin
            idle(1);
            guard++;
        end
        checkOutput("t4_bound", guard >= 200, 0);
        applyStimulus(3'b100, '0, '0, 16'h0C0C);
        checkOutput("t4_full", full[2], 1'b1);
        checkOutput("t4_ovf", ovf, 3'b000);
        drain();
        checkOutput("t4_count", obsDin.size(), 2);
        if (obsDin.size() == 2) checkOutput("t4_din2", obsDin[1], 16'h0C0C);

        // uart_tx never answers: timeout, buffer dropped, next channel served.
        applyReset();
        noDone = 1'b1;
        applyStimulus(3'b011, 16'h1111, 16'h2222, '0);
        idle(1);
        startEdge = edgeNum;
        guard = 0;
        while (timeout !== 1'b1 && guard < TMO + 20) begin
            idle(1);
            guard++;
        end
        checkOutput("t5_timeout", timeout, 1'b1);
        checkOutput("t5_cycles", edgeNum - startEdge, TMO + 1);
        checkOutput("t5_r_cleared", full[0], 1'b0);
        noDone = 1'b0;
        drain();
        checkOutput("t5_count", obsCh.size(), 2);
        if (obsCh.size() == 2) checkOutput("t5_next_ch", obsCh[1], 1);

        // Reset in the middle of WAIT with every buffer full.
        applyReset();
        maxDelay = 60;
        applyStimulus(3'b111, 16'h0111, 16'h0222, 16'h0333);
        idle(4);
        applyReset();
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (tx_start === 1'b1) starts++;
        end
        checkOutput("t6_no_start", starts, 0);

        // Randomized traffic.
        applyReset();
        maxDelay = 30;
        spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]    ld;
            logic [CW-1:0] cr, cg, cb;
            ld[0] = ($urandom_range(0, 7) == 0);
            ld[1] = ($urandom_range(0, 7) == 0);
            ld[2] = ($urandom_range(0, 7) == 0);
            cr = ($urandom_range(0, 7) == 0) ? 16'h0000 : CW'($urandom);
            cg = ($urandom_range(0, 7) == 0) ? 16'h0000 : CW'($urandom);
            cb = ($urandom_range(0, 7) == 0) ? 16'h0000 : CW'($urandom);
            applyStimulus(ld, cr, cg, cb);
        end
        spurious = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
